// File: rtl/back_propagation_output_layer_vector.sv
// Output-layer error stage for the DQN backward pass.
// Computes err[k] = expected[k] - node[k] for a whole output vector through one
// time-shared FP32 adder, with optional action masking and +/-1.0 clipping.

// Pipelined IEEE-754 single-precision adder (round to nearest even).
// Result of a valid_in cycle appears on sum_out with valid_out LATENCY cycles later.
module adder_floating_point32 #(
  parameter int LATENCY = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        valid_out,
  output logic [31:0] sum_out
);

  logic [LATENCY-1:0] vld_r;
  logic [31:0]        dat_r [LATENCY];

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    logic [31:0] y;
    logic [7:0]  ex;
    logic [7:0]  ey;
    logic [7:0]  d;
    logic [26:0] mx;
    logic [26:0] my;
    logic [27:0] sum;
    logic [9:0]  e;
    logic        sticky;
    logic        rnd;
    logic [31:0] res;
    res = 32'h0;
    if (((a[30:23] == 8'hFF) && (a[22:0] != 23'h0)) || ((b[30:23] == 8'hFF) && (b[22:0] != 23'h0))) begin
      res = 32'h7FC0_0000;
    end else if ((a[30:23] == 8'hFF) && (b[30:23] == 8'hFF)) begin
      res = (a[31] == b[31]) ? a : 32'h7FC0_0000;
    end else if (a[30:23] == 8'hFF) begin
      res = a;
    end else if (b[30:23] == 8'hFF) begin
      res = b;
    end else if ((a[30:0] == 31'h0) && (b[30:0] == 31'h0)) begin
      res = {a[31] & b[31], 31'h0};
    end else begin
      // x carries the larger magnitude, so its sign is the result sign
      if (a[30:0] >= b[30:0]) begin
        x = a;
        y = b;
      end else begin
        x = b;
        y = a;
      end
      ex = (x[30:23] == 8'h0) ? 8'd1 : x[30:23];
      ey = (y[30:23] == 8'h0) ? 8'd1 : y[30:23];
      mx = {(x[30:23] != 8'h0), x[22:0], 3'b000};
      my = {(y[30:23] != 8'h0), y[22:0], 3'b000};
      d  = ex - ey;
      if (d >= 8'd27) begin
        sticky = |my;
        my     = 27'h0;
      end else begin
        sticky = |(my & ((27'h1 << d) - 27'h1));
        my     = my >> d;
      end
      my[0] = my[0] | sticky;
      if (x[31] == y[31]) begin
        sum = {1'b0, mx} + {1'b0, my};
      end else begin
        sum = {1'b0, mx} - {1'b0, my};
      end
      e = {2'b00, ex};
      if (sum == 28'h0) begin
        res = 32'h0;  // exact cancellation yields +0
      end else begin
        if (sum[27]) begin
          sum = {1'b0, sum[27:2], sum[1] | sum[0]};
          e   = e + 10'd1;
        end else begin
          for (int i = 0; i < 26; i++) begin
            if (!sum[26] && (e > 10'd1)) begin
              sum = sum << 1;
              e   = e - 10'd1;
            end
          end
        end
        if (!sum[26]) begin
          e = 10'd0;  // subnormal result
        end
        rnd = sum[2] & (sum[1] | sum[0] | sum[3]);
        if (e >= 10'd255) begin
          res = {x[31], 31'h7F80_0000};
        end else begin
          // a mantissa carry from rounding propagates into the exponent field
          res = {x[31], e[7:0], sum[25:3]} + {31'h0, rnd};
        end
      end
    end
    return res;
  endfunction

  // Latency pipeline: stage 0 holds the fresh sum, later stages delay it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_r <= {LATENCY{1'b0}};
      for (int i = 0; i < LATENCY; i++) dat_r[i] <= 32'h0;
    end else begin
      vld_r    <= {vld_r[LATENCY-2:0], valid_in};
      dat_r[0] <= fp_add(in_a, in_b);
      for (int i = 1; i < LATENCY; i++) dat_r[i] <= dat_r[i-1];
    end
  end

  assign valid_out = vld_r[LATENCY-1];
  assign sum_out   = dat_r[LATENCY-1];

endmodule

module back_propagation_output_layer_vector #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_OUTPUTS   = 4,
  parameter int ACTION_WIDTH  = 2,
  parameter int ADDER_LATENCY = 7
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [NUM_OUTPUTS*DATA_WIDTH-1:0] i_data_expected,
  input  logic [NUM_OUTPUTS*DATA_WIDTH-1:0] i_data_node,
  input  logic [ACTION_WIDTH-1:0]           i_action,
  input  logic                              i_mask_en,
  input  logic                              i_clip_en,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] o_data,
  output logic                              o_valid
);

  localparam int CNT_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_OUTPUTS - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_DRAIN = 2'd2} state_t;

  state_t                                   state_r;
  state_t                                   state_s;
  logic [CNT_W-1:0]                         iss_cnt_r;
  logic [CNT_W-1:0]                         cap_cnt_r;
  logic [NUM_OUTPUTS*DATA_WIDTH-1:0]        exp_r;
  logic [NUM_OUTPUTS*DATA_WIDTH-1:0]        node_r;
  logic [ACTION_WIDTH-1:0]                  action_r;
  logic                                     mask_r;
  logic                                     clip_r;
  logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0]   buf_r;
  logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0]   done_vec_s;
  logic                                     accept_s;
  logic                                     add_valid_s;
  logic [DATA_WIDTH-1:0]                    add_a_s;
  logic [DATA_WIDTH-1:0]                    add_b_s;
  logic [DATA_WIDTH-1:0]                    node_word_s;
  logic                                     sum_valid_s;
  logic [DATA_WIDTH-1:0]                    sum_s;
  logic [DATA_WIDTH-1:0]                    post_s;
  logic                                     last_cap_s;

  // Masking first, then clipping; a masked slot is always +0.0
  function automatic logic [DATA_WIDTH-1:0] post_proc(input logic [CNT_W-1:0] k,
                                                      input logic [DATA_WIDTH-1:0] v,
                                                      input logic [ACTION_WIDTH-1:0] act,
                                                      input logic mask_en,
                                                      input logic clip_en);
    logic [DATA_WIDTH-1:0] r;
    r = v;
    if (mask_en && (32'(k) != 32'(act))) begin
      r = {DATA_WIDTH{1'b0}};
    end else if (clip_en && (r[30:0] > 31'h3F80_0000)) begin
      r = {r[31], 31'h3F80_0000};
    end else begin
      r = v;
    end
    return r;
  endfunction

  assign o_ready     = (state_r == ST_IDLE);
  assign accept_s    = i_valid && (state_r == ST_IDLE);
  assign node_word_s = node_r[iss_cnt_r*DATA_WIDTH +: DATA_WIDTH];
  assign add_valid_s = (state_r == ST_ISSUE);
  assign add_a_s     = exp_r[iss_cnt_r*DATA_WIDTH +: DATA_WIDTH];
  assign add_b_s     = {~node_word_s[31], node_word_s[30:0]};  // a + (-b) = a - b
  assign post_s      = post_proc(cap_cnt_r, sum_s, action_r, mask_r, clip_r);
  assign last_cap_s  = sum_valid_s && (cap_cnt_r == LAST);

  adder_floating_point32 #(.LATENCY(ADDER_LATENCY)) u_adder (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (add_valid_s),
    .in_a      (add_a_s),
    .in_b      (add_b_s),
    .valid_out (sum_valid_s),
    .sum_out   (sum_s)
  );

  // Next-state logic for IDLE -> ISSUE -> DRAIN -> IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (i_valid) state_s = ST_ISSUE; else state_s = ST_IDLE;
      ST_ISSUE: if (iss_cnt_r == LAST) state_s = ST_DRAIN; else state_s = ST_ISSUE;
      ST_DRAIN: if (last_cap_s) state_s = ST_IDLE; else state_s = ST_DRAIN;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Completed vector: buffered slots plus the final element arriving now
  always_comb begin
    done_vec_s       = buf_r;
    done_vec_s[LAST] = post_s;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Input latching and issue counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_r     <= {(NUM_OUTPUTS*DATA_WIDTH){1'b0}};
      node_r    <= {(NUM_OUTPUTS*DATA_WIDTH){1'b0}};
      action_r  <= {ACTION_WIDTH{1'b0}};
      mask_r    <= 1'b0;
      clip_r    <= 1'b0;
      iss_cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      exp_r     <= i_data_expected;
      node_r    <= i_data_node;
      action_r  <= i_action;
      mask_r    <= i_mask_en;
      clip_r    <= i_clip_en;
      iss_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_ISSUE) && (iss_cnt_r != LAST)) begin
      iss_cnt_r <= iss_cnt_r + CNT_W'(1);
    end else begin
      iss_cnt_r <= iss_cnt_r;
    end
  end

  // Result capture in issue order and completion pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_cnt_r <= {CNT_W{1'b0}};
      buf_r     <= {(NUM_OUTPUTS*DATA_WIDTH){1'b0}};
      o_data    <= {(NUM_OUTPUTS*DATA_WIDTH){1'b0}};
      o_valid   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (sum_valid_s && (state_r != ST_IDLE)) begin
        buf_r[cap_cnt_r] <= post_s;
        if (cap_cnt_r == LAST) begin
          o_data    <= done_vec_s;
          o_valid   <= 1'b1;
          cap_cnt_r <= {CNT_W{1'b0}};
        end else begin
          cap_cnt_r <= cap_cnt_r + CNT_W'(1);
        end
      end else begin
        cap_cnt_r <= cap_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_back_propagation_output_layer_vector.sv
// Bench for back_propagation_output_layer_vector: directed vector table, random
// vectors against a real-arithmetic model, streaming, mid-run reset, N=3 instance.
module tb_back_propagation_output_layer_vector;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid4 = 1'b0, mask4 = 1'b0, clip4 = 1'b0, ready4, ovalid4;
  logic [1:0]   act4 = 2'd0;
  logic [127:0] exp4 = 128'h0, node4 = 128'h0, data4;
  logic         valid3 = 1'b0, mask3 = 1'b0, clip3 = 1'b0, ready3, ovalid3;
  logic [1:0]   act3 = 2'd0;
  logic [95:0]  exp3 = 96'h0, node3 = 96'h0, data3;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  back_propagation_output_layer_vector #(.NUM_OUTPUTS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_valid(valid4), .o_ready(ready4),
    .i_data_expected(exp4), .i_data_node(node4), .i_action(act4),
    .i_mask_en(mask4), .i_clip_en(clip4), .o_data(data4), .o_valid(ovalid4));

  back_propagation_output_layer_vector #(.NUM_OUTPUTS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_valid(valid3), .o_ready(ready3),
    .i_data_expected(exp3), .i_data_node(node3), .i_action(act3),
    .i_mask_en(mask3), .i_clip_en(clip3), .o_data(data3), .o_valid(ovalid3));

  typedef struct {
    logic [127:0] e;
    logic [127:0] n;
    logic [1:0]   a;
    logic         m;
    logic         c;
    logic [127:0] want;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) $display("FAIL %s got=%h want=%h", name, got, want);
    else passes++;
  endtask

  function automatic logic [127:0] p4(input logic [31:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  // Exact real -> FP32 encoding (values used here are always exactly representable)
  function automatic logic [31:0] r2f(input real x);
    logic  s;
    real   m;
    int    e;
    int    frac;
    if (x == 0.0) return 32'h0;
    s = (x < 0.0);
    m = s ? -x : x;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    frac = int'((m - 1.0) * 8388608.0);
    return {s, e[7:0], frac[22:0]};
  endfunction

  // Apply one vector to the selected DUT; check latency, data and pulse width
  task automatic apply(input int sel, input logic [127:0] e, input logic [127:0] n,
                       input logic [1:0] a, input logic m, input logic c,
                       input logic [127:0] want, input string name);
    int   lat;
    int   bound;
    logic ov;
    bound = 0;
    while (!((sel == 3) ? ready3 : ready4) && (bound < 50)) begin @(negedge clk); bound++; end
    check({name, "_ready"}, 128'((sel == 3) ? ready3 : ready4), 128'd1);
    if (sel == 3) begin
      exp3 = e[95:0]; node3 = n[95:0]; act3 = a; mask3 = m; clip3 = c; valid3 = 1'b1;
    end else begin
      exp4 = e; node4 = n; act4 = a; mask4 = m; clip4 = c; valid4 = 1'b1;
    end
    @(negedge clk);
    // inputs are latched: scramble them right after accept
    valid3 = 1'b0; valid4 = 1'b0;
    exp4 = {$urandom, $urandom, $urandom, $urandom}; node4 = {$urandom, $urandom, $urandom, $urandom};
    exp3 = exp4[95:0]; node3 = node4[95:0];
    act4 = 2'($urandom); act3 = act4; mask4 = ~m; mask3 = ~m; clip4 = ~c; clip3 = ~c;
    lat = 1;
    ov = (sel == 3) ? ovalid3 : ovalid4;
    while (!ov && (lat < 40)) begin
      @(negedge clk);
      lat++;
      ov = (sel == 3) ? ovalid3 : ovalid4;
    end
    check({name, "_lat"}, 128'(lat), 128'((sel == 3) ? 11 : 12));
    if (sel == 3) check({name, "_data"}, {32'h0, data3}, {32'h0, want[95:0]});
    else          check({name, "_data"}, data4, want);
    @(negedge clk);
    check({name, "_pulse"}, 128'((sel == 3) ? ovalid3 : ovalid4), 128'd0);
  endtask

  initial begin
    logic [127:0] e, n, want;
    logic [1:0]   a;
    logic         m, c;
    real          re, rn, err;
    int           ia, sa, pulses[$];

    tbl[0] = '{p4(32'h40400000, 32'h40000000, 32'h3F800000, 32'h3F000000),
               p4(32'h3F800000, 32'h3F000000, 32'h3F000000, 32'h3E800000), 2'd0, 1'b0, 1'b0,
               p4(32'h40000000, 32'h3FC00000, 32'h3F000000, 32'h3E800000)};
    tbl[1] = '{p4(32'h40400000, 32'hC0000000, 32'h3F000000, 32'h3F800000),
               p4(32'h3F800000, 32'h3F800000, 32'h00000000, 32'h3F800000), 2'd0, 1'b0, 1'b1,
               p4(32'h3F800000, 32'hBF800000, 32'h3F000000, 32'h00000000)};
    tbl[2] = '{tbl[0].e, tbl[0].n, 2'd2, 1'b1, 1'b0,
               p4(32'h00000000, 32'h00000000, 32'h3F000000, 32'h00000000)};
    tbl[3] = '{tbl[0].e, tbl[0].n, 2'd3, 1'b1, 1'b0,
               p4(32'h00000000, 32'h00000000, 32'h00000000, 32'h3E800000)};
    tbl[4] = '{tbl[1].e, tbl[1].n, 2'd0, 1'b1, 1'b1,
               p4(32'h3F800000, 32'h00000000, 32'h00000000, 32'h00000000)};
    tbl[5] = '{p4(32'h3E800000, 32'hBF000000, 32'h3FC00000, 32'hC0800000),
               p4(32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h00000000), 2'd0, 1'b0, 1'b1,
               p4(32'hBE800000, 32'hBF800000, 32'h3F800000, 32'hBF800000)};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready4", 128'(ready4), 128'd1);
    check("rst_valid4", 128'(ovalid4), 128'd0);
    check("rst_data4", data4, 128'h0);
    check("rst_ready3", 128'(ready3), 128'd1);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) apply(4, tbl[i].e, tbl[i].n, tbl[i].a, tbl[i].m, tbl[i].c, tbl[i].want, $sformatf("tbl%0d", i));

    // Randomized vectors against a real-arithmetic model
    for (int t = 0; t < 20; t++) begin
      a = 2'($urandom); m = 1'($urandom); c = 1'($urandom);
      for (int k = 0; k < 4; k++) begin
        ia = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 131072)) - 65536 : int'($urandom_range(0, 512)) - 256;
        sa = $urandom_range(4, 8);
        re = real'(ia) / (2.0 ** sa);
        ia = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 131072)) - 65536 : int'($urandom_range(0, 512)) - 256;
        sa = $urandom_range(4, 8);
        rn = ($urandom_range(0, 7) == 0) ? re : real'(ia) / (2.0 ** sa);
        err = re - rn;
        if (m && (k != int'(a))) err = 0.0;
        if (c && (err > 1.0)) err = 1.0;
        if (c && (err < -1.0)) err = -1.0;
        e[k*32 +: 32] = r2f(re);
        n[k*32 +: 32] = r2f(rn);
        want[k*32 +: 32] = r2f(err);
      end
      apply(4, e, n, a, m, c, want, $sformatf("rnd%0d", t));
    end

    // i_valid held high for 30 cycles: accepts only when ready, one pulse per 12 cycles
    exp4 = tbl[0].e; node4 = tbl[0].n; act4 = 2'd0; mask4 = 1'b0; clip4 = 1'b0; valid4 = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (i == 30) valid4 = 1'b0;
      if (i == 5) check("stream_busy", 128'(ready4), 128'd0);
      if (ovalid4) begin
        pulses.push_back(i);
        check("stream_data", data4, tbl[0].want);
      end
    end
    check("stream_count", 128'(pulses.size()), 128'd3);
    foreach (pulses[j]) check($sformatf("stream_pos%0d", j), 128'(pulses[j]), 128'(12 * (j + 1)));

    // Reset one cycle at accept+5 aborts the vector
    exp4 = tbl[0].e; node4 = tbl[0].n; act4 = 2'd0; mask4 = 1'b0; clip4 = 1'b0; valid4 = 1'b1;
    @(negedge clk);
    valid4 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_ready", 128'(ready4), 128'd1);
    check("abort_valid", 128'(ovalid4), 128'd0);
    check("abort_data", data4, 128'h0);
    pulses.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ovalid4) pulses.push_back(i);
    end
    check("abort_no_pulse", 128'(pulses.size()), 128'd0);
    apply(4, tbl[0].e, tbl[0].n, 2'd0, 1'b0, 1'b0, tbl[0].want, "after_abort");

    // NUM_OUTPUTS = 3 instance
    apply(3, tbl[0].e, tbl[0].n, 2'd3, 1'b1, 1'b0, 128'h0, "n3_mask_all");
    apply(3, tbl[0].e, tbl[0].n, 2'd0, 1'b0, 1'b0, tbl[0].want, "n3_plain");
    apply(3, tbl[1].e, tbl[1].n, 2'd1, 1'b1, 1'b1,
          p4(32'h00000000, 32'hBF800000, 32'h00000000, 32'h00000000), "n3_mask_clip");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
